// File: rtl/cache_line_alloc.sv
// cache_line_alloc
// Miss/allocation controller for an N-way cache.
// A hit issues a replacement-policy update for the hit way(s) on the cycle after
// the request is accepted. A miss refills the policy's victim way: it burst-reads
// every word of the line from the back end into that way's data memory, writes
// the tag, and then issues the policy update for the refilled way.
// All outputs are decoded from the current state, so asserting reset forces them
// to their idle values immediately.

module cache_line_alloc #(
    parameter int N_WAYS     = 8,
    parameter int NWAY_W     = $clog2(N_WAYS),
    parameter int LINE_OFF_W = 7,
    parameter int WORD_OFF_W = 3,
    parameter int TAG_W      = 20,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = TAG_W + LINE_OFF_W + WORD_OFF_W
) (
    input  logic                             clk,
    input  logic                             reset,

    // Request from the tag-compare stage
    input  logic                             req_valid,
    input  logic [ADDR_W-1:0]                req_addr,
    output logic                             req_ready,
    input  logic [N_WAYS-1:0]                way_hit,

    // Replacement policy
    input  logic [NWAY_W-1:0]                way_select_bin,
    output logic                             pol_write_en,
    output logic [N_WAYS-1:0]                pol_way_hit,
    output logic [LINE_OFF_W-1:0]            pol_line_addr,

    // Back-end read port
    output logic                             be_valid,
    output logic [ADDR_W-1:0]                be_addr,
    input  logic                             be_ready,
    input  logic [DATA_W-1:0]                be_rdata,

    // Data memory write port
    output logic [N_WAYS-1:0]                dmem_we,
    output logic [LINE_OFF_W+WORD_OFF_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]                dmem_wdata,

    // Tag/valid memory write port
    output logic [N_WAYS-1:0]                tag_we,
    output logic [LINE_OFF_W-1:0]            tag_addr,
    output logic [TAG_W-1:0]                 tag_wdata,

    // Completion
    output logic                             done,
    output logic                             done_hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        TAG_WR = 2'd2,
        UPD    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [WORD_OFF_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [LINE_OFF_W-1:0]   line_q, line_d;
    logic [N_WAYS-1:0]       way_hit_q, way_hit_d;
    logic [NWAY_W-1:0]       victim_q, victim_d;
    logic                    done_hit_q, done_hit_d;

    // Request address fields; the word offset of the request is not needed
    // because a refill always fetches the whole line starting at word 0.
    logic [TAG_W-1:0]        req_tag;
    logic [LINE_OFF_W-1:0]   req_line;
    logic                    unused_req_word;

    assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
    assign req_line        = req_addr[WORD_OFF_W +: LINE_OFF_W];
    assign unused_req_word = ^req_addr[WORD_OFF_W-1:0];

    logic [N_WAYS-1:0]       victim_oh;
    logic                    last_word;

    assign last_word = &word_cnt_q;

    // Decode the latched victim index into a one-hot way mask.
    always_comb begin
        victim_oh           = '0;
        victim_oh[victim_q] = 1'b1;
    end

    // State and request-context registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            tag_q      <= '0;
            line_q     <= '0;
            way_hit_q  <= '0;
            victim_q   <= '0;
            done_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            way_hit_q  <= way_hit_d;
            victim_q   <= victim_d;
            done_hit_q <= done_hit_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        tag_d         = tag_q;
        line_d        = line_q;
        way_hit_d     = way_hit_q;
        victim_d      = victim_q;
        done_hit_d    = done_hit_q;

        req_ready     = 1'b0;
        pol_write_en  = 1'b0;
        pol_way_hit   = '0;
        pol_line_addr = '0;
        be_valid      = 1'b0;
        be_addr       = '0;
        dmem_we       = '0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        tag_we        = '0;
        tag_addr      = '0;
        tag_wdata     = '0;
        done          = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_d     = req_tag;
                    line_d    = req_line;
                    way_hit_d = way_hit;
                    victim_d  = way_select_bin;
                    if (|way_hit) begin
                        // Hit: go straight to the policy update. A multi-hot
                        // hit vector is forwarded to the policy untouched.
                        done_hit_d = 1'b1;
                        state_d    = UPD;
                    end else begin
                        done_hit_d = 1'b0;
                        word_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
            end

            FILL: begin
                // The request stays up, with a stable address, until the back
                // end delivers the word; the data is written in the same cycle.
                be_valid = 1'b1;
                be_addr  = {tag_q, line_q, word_cnt_q};
                if (be_ready) begin
                    dmem_we    = victim_oh;
                    dmem_addr  = {line_q, word_cnt_q};
                    dmem_wdata = be_rdata;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = TAG_WR;
                    end
                end
            end

            TAG_WR: begin
                // Tag is written only once the whole line is in place, so a
                // reset mid-refill leaves the way invalid.
                tag_we    = victim_oh;
                tag_addr  = line_q;
                tag_wdata = tag_q;
                state_d   = UPD;
            end

            UPD: begin
                pol_write_en  = 1'b1;
                pol_line_addr = line_q;
                pol_way_hit   = done_hit_q ? way_hit_q : victim_oh;
                done          = 1'b1;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done_hit = done_hit_q;

endmodule

// File: tb/tb_cache_line_alloc.sv
// tb_cache_line_alloc
// Directed bench for cache_line_alloc. A per-cycle scoreboard derives the
// expected outputs from the transaction rules (hit -> update next cycle; miss ->
// one back-end word per ready cycle, tag write, update), and directed scenarios
// add literal expectations for latency, addresses and way masks.

module tb_cache_line_alloc;

    localparam int N_WAYS     = 8;
    localparam int NWAY_W     = 3;
    localparam int LINE_OFF_W = 7;
    localparam int WORD_OFF_W = 3;
    localparam int TAG_W      = 20;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = TAG_W + LINE_OFF_W + WORD_OFF_W;
    localparam int WORDS      = 1 << WORD_OFF_W;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             req_valid;
    logic [ADDR_W-1:0]                req_addr;
    logic                             req_ready;
    logic [N_WAYS-1:0]                way_hit;
    logic [NWAY_W-1:0]                way_select_bin;
    logic                             pol_write_en;
    logic [N_WAYS-1:0]                pol_way_hit;
    logic [LINE_OFF_W-1:0]            pol_line_addr;
    logic                             be_valid;
    logic [ADDR_W-1:0]                be_addr;
    logic                             be_ready;
    logic [DATA_W-1:0]                be_rdata;
    logic [N_WAYS-1:0]                dmem_we;
    logic [LINE_OFF_W+WORD_OFF_W-1:0] dmem_addr;
    logic [DATA_W-1:0]                dmem_wdata;
    logic [N_WAYS-1:0]                tag_we;
    logic [LINE_OFF_W-1:0]            tag_addr;
    logic [TAG_W-1:0]                 tag_wdata;
    logic                             done;
    logic                             done_hit;

    always #5 clk = ~clk;

    cache_line_alloc dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .way_hit        (way_hit),
        .way_select_bin (way_select_bin),
        .pol_write_en   (pol_write_en),
        .pol_way_hit    (pol_way_hit),
        .pol_line_addr  (pol_line_addr),
        .be_valid       (be_valid),
        .be_addr        (be_addr),
        .be_ready       (be_ready),
        .be_rdata       (be_rdata),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .tag_we         (tag_we),
        .tag_addr       (tag_addr),
        .tag_wdata      (tag_wdata),
        .done           (done),
        .done_hit       (done_hit)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Back-end memory contents: a fixed scramble of the word address.
    function automatic logic [DATA_W-1:0] data_fn(input logic [ADDR_W-1:0] a);
        return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    always_comb be_rdata = data_fn(be_addr);

    // Model of the transaction in flight
    bit                    m_busy = 1'b0;
    bit                    m_hit;
    logic [TAG_W-1:0]      m_tag;
    logic [LINE_OFF_W-1:0] m_line;
    logic [N_WAYS-1:0]     m_way_hit;
    logic [NWAY_W-1:0]     m_victim;
    int                    m_words;
    bit                    m_tag_done;
    int                    m_age;
    int                    m_stalls;

    // Observations used by the directed literal checks
    int                    cyc = 0;
    int                    done_cnt = 0;
    int                    last_done_cyc = 0;
    int                    last_latency = 0;
    logic [N_WAYS-1:0]     last_pol_way = '0;
    logic [ADDR_W-1:0]     first_be_addr = '0;
    logic [TAG_W-1:0]      last_tag_wdata = '0;
    int                    dmem_obs_cnt = 0;
    int                    be_obs_cnt = 0;
    int                    tag_wr_total = 0;

    // Back-end stall injection
    int                    stall_word = -1;
    int                    stall_left = 0;

    // Scoreboard: compares every output on every falling edge.
    initial begin
        logic              fill_exp, tag_exp, upd_exp;
        logic [N_WAYS-1:0] oh;
        logic [ADDR_W-1:0] exp_addr;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("reset_outputs", {req_ready, be_valid, |dmem_we, |tag_we, pol_write_en, done}, 6'b100000);
                m_busy = 1'b0;
            end else if (!m_busy) begin
                check("idle_outputs", {req_ready, be_valid, |dmem_we, |tag_we, pol_write_en, done}, 6'b100000);
                if (req_valid) begin
                    m_busy       = 1'b1;
                    m_hit        = |way_hit;
                    m_tag        = req_addr[ADDR_W-1 -: TAG_W];
                    m_line       = req_addr[WORD_OFF_W +: LINE_OFF_W];
                    m_way_hit    = way_hit;
                    m_victim     = way_select_bin;
                    m_words      = 0;
                    m_tag_done   = 1'b0;
                    m_age        = 0;
                    m_stalls     = 0;
                    dmem_obs_cnt = 0;
                    be_obs_cnt   = 0;
                end
            end else begin
                m_age++;
                oh           = '0;
                oh[m_victim] = 1'b1;
                fill_exp     = !m_hit && (m_words < WORDS);
                tag_exp      = !m_hit && (m_words == WORDS) && !m_tag_done;
                upd_exp      = m_hit ? (m_age == 1) : m_tag_done;

                check("busy_req_ready", req_ready, 1'b0);
                check("be_valid", be_valid, fill_exp);
                if (fill_exp) begin
                    exp_addr = {m_tag, m_line, WORD_OFF_W'(m_words)};
                    check("be_addr", be_addr, exp_addr);
                    if (m_words == 0) first_be_addr = be_addr;
                    if (be_ready) begin
                        check("dmem_we", dmem_we, oh);
                        check("dmem_addr", dmem_addr, {m_line, WORD_OFF_W'(m_words)});
                        check("dmem_wdata", dmem_wdata, data_fn(exp_addr));
                        m_words++;
                    end else begin
                        check("dmem_we_stall", dmem_we, '0);
                        m_stalls++;
                    end
                end else begin
                    check("dmem_we_quiet", dmem_we, '0);
                end

                check("tag_we", tag_we, tag_exp ? oh : '0);
                if (tag_exp) begin
                    check("tag_addr", tag_addr, m_line);
                    check("tag_wdata", tag_wdata, m_tag);
                    last_tag_wdata = tag_wdata;
                    m_tag_done     = 1'b1;
                end

                check("pol_done", {pol_write_en, done}, upd_exp ? 2'b11 : 2'b00);
                if (upd_exp) begin
                    check("pol_line_addr", pol_line_addr, m_line);
                    check("pol_way_hit", pol_way_hit, m_hit ? m_way_hit : oh);
                    check("done_hit", done_hit, m_hit);
                    check("latency", m_age, m_hit ? 1 : WORDS + 2 + m_stalls);
                    last_latency  = m_age;
                    last_pol_way  = pol_way_hit;
                    last_done_cyc = cyc;
                    done_cnt++;
                    m_busy = 1'b0;
                end
            end
            if (|dmem_we) dmem_obs_cnt++;
            if (be_valid) be_obs_cnt++;
            if (|tag_we)  tag_wr_total++;
        end
    end

    // Back end: ready every cycle except for injected stalls at one word.
    initial begin
        be_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (m_busy && !m_hit && m_words == stall_word && stall_left > 0) begin
                be_ready = 1'b0;
                stall_left--;
            end else begin
                be_ready = 1'b1;
            end
        end
    end

    // One-cycle request; inputs are scrambled after the accept edge so the
    // DUT must rely on what it latched.
    task automatic send_req(input logic [TAG_W-1:0] t, input logic [LINE_OFF_W-1:0] l,
                            input logic [N_WAYS-1:0] wh, input logic [NWAY_W-1:0] v);
        @(posedge clk);
        #1;
        req_valid      = 1'b1;
        req_addr       = {t, l, 3'd5};
        way_hit        = wh;
        way_select_bin = v;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        req_addr       = ~req_addr;
        way_hit        = 8'hFF;
        way_select_bin = ~v;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_timeout"}, m_busy, 1'b0);
    endtask

    initial begin
        int tag_before;
        int done_before;
        int first_done_cyc;
        int first_latency;
        int n;

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        way_hit        = '0;
        way_select_bin = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_done_hit", done_hit, 1'b0);

        // Hit: line 5, way 4
        send_req(20'h12345, 7'd5, 8'h10, 3'd2);
        wait_idle("hit", 20);
        check("hit_latency", last_latency, 1);
        check("hit_pol_way", last_pol_way, 8'h10);
        check("hit_no_be_valid", be_obs_cnt, 0);

        // Miss: tag 0xABCDE, line 3, victim 6
        send_req(20'hABCDE, 7'd3, 8'h00, 3'd6);
        wait_idle("miss", 40);
        check("miss_latency", last_latency, 10);
        check("miss_pol_way", last_pol_way, 8'h40);
        check("miss_first_be_addr", first_be_addr, 30'h2AF3_7818);
        check("miss_tag_wdata", last_tag_wdata, 20'hABCDE);
        check("miss_dmem_writes", dmem_obs_cnt, 8);

        // Back-pressure: 3 stall cycles at word 4, last set, victim 0
        stall_word = 4;
        stall_left = 3;
        send_req(20'h0F0F0, 7'h7F, 8'h00, 3'd0);
        wait_idle("stall", 40);
        check("stall_latency", last_latency, 13);
        check("stall_dmem_writes", dmem_obs_cnt, 8);
        check("stall_pol_way", last_pol_way, 8'h01);
        stall_word = -1;

        // Multi-hot hit passes through unchanged
        send_req(20'h00001, 7'd0, 8'h81, 3'd5);
        wait_idle("multihot", 20);
        check("multihot_pol_way", last_pol_way, 8'h81);

        // Abort: reset after word 2 of a refill
        tag_before  = tag_wr_total;
        done_before = done_cnt;
        send_req(20'h55555, 7'd9, 8'h00, 3'd7);
        n = 0;
        while (m_words < 3 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach_word3", m_words, 3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_quiet", {be_valid, |dmem_we, |tag_we, pol_write_en, done}, 5'b00000);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        check("abort_no_tag_we", tag_wr_total, tag_before);
        check("abort_no_done", done_cnt, done_before);
        send_req(20'h2468A, 7'd10, 8'h04, 3'd1);
        wait_idle("after_abort", 20);
        check("after_abort_latency", last_latency, 1);
        check("after_abort_done_cnt", done_cnt, done_before + 1);
        check("after_abort_tag_total", tag_wr_total, tag_before);

        // Busy: req_valid held through a miss, hit accepted right after done
        done_before = done_cnt;
        @(posedge clk);
        #1;
        req_valid      = 1'b1;
        req_addr       = {20'h13579, 7'd20, 3'd0};
        way_hit        = 8'h00;
        way_select_bin = 3'd3;
        @(posedge clk);
        #1;
        req_addr       = {20'h13579, 7'd21, 3'd0};
        way_hit        = 8'h02;
        way_select_bin = 3'd4;
        n = 0;
        while (done_cnt == done_before && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("busy_first_done", done_cnt, done_before + 1);
        first_done_cyc = last_done_cyc;
        first_latency  = last_latency;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle("busy_second", 20);
        check("busy_first_latency", first_latency, 10);
        check("busy_done_spacing", last_done_cyc - first_done_cyc, 2);
        check("busy_second_pol_way", last_pol_way, 8'h02);
        check("busy_done_cnt", done_cnt, done_before + 2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
